// File: rtl/scc_wave_regs_pkg.sv
// ----------------------------------------------------------------------------
// scc_wave_regs_pkg
// Shared constants and types for the wave-table sound register block:
//   - address map boundaries (wave RAM, frequency, volume, enable, deformation)
//   - slot sequencer state encoding
//   - channel count and wave RAM depth
// ----------------------------------------------------------------------------
package scc_wave_regs_pkg;

    localparam int NUM_CH     = 5;
    localparam int WAVE_DEPTH = 160;   // 5 channels x 32 bytes

    localparam logic [7:0] WAVE_END    = 8'h9F;
    localparam logic [7:0] FREQ_BASE   = 8'hA0;
    localparam logic [7:0] VOL_BASE    = 8'hAA;
    localparam logic [7:0] EN_ADDR     = 8'hAF;
    localparam logic [7:0] DEFORM_BASE = 8'hC0;
    localparam logic [7:0] DEFORM_END  = 8'hDF;

    // Periods below this are too fast to be meaningful; the channel freezes.
    localparam logic [11:0] FREQ_MIN = 12'd9;

    typedef enum logic [2:0] {
        SLOT_FETCH0 = 3'd0,
        SLOT_FETCH1 = 3'd1,
        SLOT_FETCH2 = 3'd2,
        SLOT_FETCH3 = 3'd3,
        SLOT_FETCH4 = 3'd4,
        SLOT_CPU    = 3'd5
    } slot_e;

endpackage

// File: rtl/scc_chan_counter.sv
// ----------------------------------------------------------------------------
// scc_chan_counter
// One channel's 12-bit period down-counter and 5-bit wave phase.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clk_en         sound-rate enable
//   freq           current 12-bit period register of this channel
//   load           CPU frequency write this cycle (takes priority over reload)
//   load_val       new 12-bit period written by the CPU
//   phase_clr      when loading, also return phase to 0
//   phase          current wave phase (0..31)
// ----------------------------------------------------------------------------
module scc_chan_counter
    import scc_wave_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic [11:0] freq,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        phase_clr,
    output logic [4:0]  phase
);

    logic [11:0] cnt_reg;
    logic [4:0]  phase_reg;

    // The count "hits 0" on the edge where it would decrement to 0; reloading
    // on that edge gives a phase step every freq clk_en ticks exactly. A count
    // already at 0 (after reset) also reloads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg   <= '0;
            phase_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
            if (phase_clr) begin
                phase_reg <= '0;
            end
        end else if (clk_en && (freq >= FREQ_MIN)) begin
            if (cnt_reg <= 12'd1) begin
                cnt_reg   <= freq;
                phase_reg <= phase_reg + 5'd1;
            end else begin
                cnt_reg <= cnt_reg - 12'd1;
            end
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/scc_wave_regs.sv
// ----------------------------------------------------------------------------
// scc_wave_regs
// Five-channel wave-table register block. A six-slot sequencer (FETCH0..4,
// CPU) shares one 160x8 wave RAM between audio sample fetch and CPU access.
// Optional feature macro: SCC_DEFORM_EN (deformation register at C0-DF).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clk_en         sound-rate enable, advances the slot sequencer
//   req, wrt       access request (level, held until ack), 1=write
//   adr, dbo       register address, write data
//   dbi            read data, valid from the ack cycle until the next ack
//   ack            one-clk completion pulse
//   sample         5 x signed 8-bit current samples, ch1 in [7:0]
//   vol            5 x 4-bit volumes, ch1 in [3:0]
//   ch_en          channel enable mask
// ----------------------------------------------------------------------------
module scc_wave_regs
    import scc_wave_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        req,
    input  logic        wrt,
    input  logic [7:0]  adr,
    input  logic [7:0]  dbo,
    output logic [7:0]  dbi,
    output logic        ack,
    output logic [39:0] sample,
    output logic [19:0] vol,
    output logic [4:0]  ch_en
);

    slot_e       slot_reg, slot_next;
    logic [2:0]  slot_idx;
    logic        armed_reg;
    logic        ack_reg;
    logic [7:0]  dbi_reg;
    logic [4:0]  en_reg;
    logic [11:0] freq_reg [NUM_CH];
    logic [11:0] freq_new [NUM_CH];
    logic [3:0]  vol_reg  [NUM_CH];
    logic [7:0]  sample_reg [NUM_CH];
    logic [4:0]  phase_w  [NUM_CH];
    logic [NUM_CH-1:0] freq_lo_hit, freq_hi_hit, vol_hit, freq_wr;

    logic        access_go, do_write;
    logic        is_wave, is_deform;
    logic        phase_clr, wave_lock;
    logic [7:0]  deform_rd;
    logic [4:0]  fetch_phase;
    logic [7:0]  ram_addr, ram_rd, rd_data;
    logic        ram_we;
    logic [7:0]  wave_mem [WAVE_DEPTH];

    // ---------------- slot sequencer ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_reg <= SLOT_FETCH0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    always_comb begin
        slot_next = slot_reg;
        if (clk_en) begin
            if (slot_reg == SLOT_CPU) begin
                slot_next = SLOT_FETCH0;
            end else begin
                slot_next = slot_e'(slot_reg + 3'd1);
            end
        end
    end

    assign slot_idx = slot_reg;

    // armed_reg blocks a second ack while req stays high; it re-arms once req
    // has been seen low for at least one clk.
    assign access_go = clk_en && (slot_reg == SLOT_CPU) && req && armed_reg;
    assign do_write  = access_go && wrt;

    // ---------------- address decode ----------------
    assign is_wave   = (adr <= WAVE_END);
    assign is_deform = (adr >= DEFORM_BASE) && (adr <= DEFORM_END);

    // ---------------- optional deformation register ----------------
`ifdef SCC_DEFORM_EN
    logic [7:0] deform_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deform_reg <= '0;
        end else if (do_write && is_deform) begin
            deform_reg <= dbo;
        end
    end

    assign deform_rd = deform_reg;
    assign phase_clr = deform_reg[5];
    assign wave_lock = deform_reg[6];
`else
    assign deform_rd = 8'hFF;
    assign phase_clr = 1'b0;
    assign wave_lock = 1'b0;
`endif

    // ---------------- per-channel registers, counters, sample lanes --------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign freq_lo_hit[gi] = (adr == FREQ_BASE + 8'(2 * gi));
            assign freq_hi_hit[gi] = (adr == FREQ_BASE + 8'(2 * gi + 1));
            assign vol_hit[gi]     = (adr == VOL_BASE + 8'(gi));
            assign freq_wr[gi]     = do_write && (freq_lo_hit[gi] || freq_hi_hit[gi]);
            assign freq_new[gi]    = freq_hi_hit[gi] ? {dbo[3:0], freq_reg[gi][7:0]}
                                                     : {freq_reg[gi][11:8], dbo};

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    freq_reg[gi] <= '0;
                    vol_reg[gi]  <= '0;
                end else begin
                    if (freq_wr[gi]) begin
                        freq_reg[gi] <= freq_new[gi];
                    end
                    if (do_write && vol_hit[gi]) begin
                        vol_reg[gi] <= dbo[3:0];
                    end
                end
            end

            scc_chan_counter u_cnt (
                .clk       (clk),
                .reset_n   (reset_n),
                .clk_en    (clk_en),
                .freq      (freq_reg[gi]),
                .load      (freq_wr[gi]),
                .load_val  (freq_new[gi]),
                .phase_clr (phase_clr),
                .phase     (phase_w[gi])
            );

            // Lane gi captures the RAM word on its own FETCH slot edge.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sample_reg[gi] <= '0;
                end else if (clk_en && (slot_idx == 3'(gi))) begin
                    sample_reg[gi] <= ram_rd;
                end
            end

            assign sample[gi*8 +: 8] = sample_reg[gi];
            assign vol[gi*4 +: 4]    = vol_reg[gi];
        end
    endgenerate

    // ---------------- shared wave RAM ----------------
    always_comb begin
        fetch_phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (slot_idx == 3'(i)) begin
                fetch_phase = phase_w[i];
            end
        end
    end

    // Channel n's 32 bytes sit at n*32, so the fetch address is {n, phase}.
    assign ram_addr = (slot_reg == SLOT_CPU) ? adr : {slot_idx, fetch_phase};
    assign ram_we   = do_write && is_wave && !wave_lock;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            wave_mem[ram_addr] <= dbo;
        end
    end

    assign ram_rd = wave_mem[ram_addr];

    // ---------------- CPU read mux and handshake ----------------
    always_comb begin
        rd_data = 8'hFF;
        if (is_wave) begin
            rd_data = ram_rd;
        end else if (adr == EN_ADDR) begin
            rd_data = {3'b000, en_reg};
        end else if (is_deform) begin
            rd_data = deform_rd;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (freq_lo_hit[i]) begin
                rd_data = freq_reg[i][7:0];
            end
            if (freq_hi_hit[i]) begin
                rd_data = {4'h0, freq_reg[i][11:8]};
            end
            if (vol_hit[i]) begin
                rd_data = {4'h0, vol_reg[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_reg   <= 1'b0;
            dbi_reg   <= '0;
            en_reg    <= '0;
            armed_reg <= 1'b1;
        end else begin
            ack_reg <= access_go;
            if (access_go && !wrt) begin
                dbi_reg <= rd_data;
            end
            if (do_write && (adr == EN_ADDR)) begin
                en_reg <= dbo[4:0];
            end
            if (access_go) begin
                armed_reg <= 1'b0;
            end else if (!req) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign ack   = ack_reg;
    assign dbi   = dbi_reg;
    assign ch_en = en_reg;

endmodule

// File: tb/tb_scc_wave_regs.sv
// ----------------------------------------------------------------------------
// tb_scc_wave_regs
// Self-checking bench for scc_wave_regs: register table, wave playback rate,
// frozen channels, req/ack handshake and reset during a pending request.
// clk_en is high on every other clk, so one slot lasts two clks.
// ----------------------------------------------------------------------------
module tb_scc_wave_regs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        req = 1'b0;
    logic        wrt = 1'b0;
    logic [7:0]  adr = 8'h00;
    logic [7:0]  dbo = 8'h00;
    logic [7:0]  dbi;
    logic        ack;
    logic [39:0] sample;
    logic [19:0] vol;
    logic [4:0]  ch_en;

    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    logic [7:0] exp_q [$];

`ifdef SCC_DEFORM_EN
    localparam logic [7:0] C0_EXP = 8'h20;
`else
    localparam logic [7:0] C0_EXP = 8'hFF;
`endif

    scc_wave_regs dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .req     (req),
        .wrt     (wrt),
        .adr     (adr),
        .dbo     (dbo),
        .dbi     (dbi),
        .ack     (ack),
        .sample  (sample),
        .vol     (vol),
        .ch_en   (ch_en)
    );

    always #5 clk = ~clk;
    always @(negedge clk) clk_en = ~clk_en;
    always @(posedge clk) if (clk_en) en_cnt <= en_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns after n more clk_en edges, sampled #1 after the last one.
    task automatic wait_en(input int n);
        int target;
        target = en_cnt + n;
        do begin
            @(posedge clk); #1;
        end while (en_cnt < target);
    endtask

    // Waits for ack with a bound; pops and checks read data from the queue.
    task automatic wait_ack(input string name, input logic w, output int lat);
        logic       got;
        logic [7:0] e;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ack) got = 1'b1;
        end
        chk({name, "_ack_seen"}, got, 1'b1);
        chk({name, "_ack_latency_ok"}, (lat <= 12), 1'b1);
        if (!w) begin
            e = exp_q.pop_front();
            if (got) chk({name, "_dbi"}, dbi, e);
        end
    endtask

    task automatic access(input string name, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] e);
        int lat;
        @(negedge clk);
        req = 1'b1; wrt = w; adr = a; dbo = d;
        if (!w) exp_q.push_back(e);
        wait_ack(name, w, lat);
        $display("access %s w=%0d adr=%02h dbo=%02h dbi=%02h lat=%0d", name, w, a, d, dbi, lat);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        chk({name, "_ack_single"}, ack, 1'b0);
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;

    vec_t vt [18];

    initial begin
        int         lat, n_chg, t_first, t_last, extra;
        logic [7:0] prev, s1, s2;
        logic       changed, seen;
        int         e0;

        vt[0]  = '{1'b1, 8'h23, 8'h5A, 8'h00};
        vt[1]  = '{1'b0, 8'h23, 8'h00, 8'h5A};
        vt[2]  = '{1'b1, 8'h85, 8'hC3, 8'h00};
        vt[3]  = '{1'b0, 8'h85, 8'h00, 8'hC3};
        vt[4]  = '{1'b1, 8'hAA, 8'h17, 8'h00};
        vt[5]  = '{1'b0, 8'hAA, 8'h00, 8'h07};
        vt[6]  = '{1'b1, 8'hAF, 8'hFF, 8'h00};
        vt[7]  = '{1'b0, 8'hAF, 8'h00, 8'h1F};
        vt[8]  = '{1'b1, 8'hA3, 8'hAB, 8'h00};
        vt[9]  = '{1'b0, 8'hA3, 8'h00, 8'h0B};
        vt[10] = '{1'b1, 8'hA2, 8'h5C, 8'h00};
        vt[11] = '{1'b0, 8'hA2, 8'h00, 8'h5C};
        vt[12] = '{1'b1, 8'hB0, 8'h12, 8'h00};
        vt[13] = '{1'b0, 8'hB0, 8'h00, 8'hFF};
        vt[14] = '{1'b1, 8'hC0, 8'h20, 8'h00};
        vt[15] = '{1'b0, 8'hC0, 8'h00, C0_EXP};
        vt[16] = '{1'b1, 8'hC0, 8'h00, 8'h00};
        vt[17] = '{1'b0, 8'hE5, 8'h00, 8'hFF};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample", sample, 40'h0);
        chk("rst_vol", vol, 20'h0);
        chk("rst_ch_en", ch_en, 5'h0);
        chk("rst_dbi", dbi, 8'h0);
        chk("rst_ack", ack, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- register table ----
        for (int i = 0; i < 18; i++) begin
            access($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].e);
        end
        chk("vol_out", vol, 20'h00007);
        chk("ch_en_out", ch_en, 5'h1F);

        // ---- ch1 playback: wave byte k = k, period 0x010 ----
        for (int k = 0; k < 32; k++) begin
            access($sformatf("wave%0d", k), 1'b1, 8'(k), 8'(k), 8'h00);
        end
        access("f1_hi", 1'b1, 8'hA1, 8'h00, 8'h00);
        access("f1_lo", 1'b1, 8'hA0, 8'h10, 8'h00);
        prev = sample[7:0];
        n_chg = 0; t_first = 0; t_last = 0;
        for (int it = 0; it < 2000 && n_chg < 33; it++) begin
            wait_en(1);
            if (sample[7:0] != prev) begin
                chk("ch1_step", sample[7:0], (prev + 8'd1) & 8'h1F);
                $display("ch1 step %0d -> %0d at en %0d", prev, sample[7:0], en_cnt);
                prev = sample[7:0];
                n_chg++;
                if (n_chg == 1) t_first = en_cnt;
                t_last = en_cnt;
            end
        end
        chk("ch1_step_count", n_chg, 33);
        chk("ch1_period_512", ((t_last - t_first) >= 506) && ((t_last - t_first) <= 518), 1'b1);

        // ---- freeze ch1 below the minimum period; phase must be kept ----
        seen = 1'b0;
        for (int it = 0; it < 1000 && !seen; it++) begin
            wait_en(1);
            if (sample[7:0] == 8'd5) seen = 1'b1;
        end
        chk("ch1_reach5", seen, 1'b1);
        access("f1_freeze", 1'b1, 8'hA0, 8'h05, 8'h00);
        wait_en(8);
        s1 = sample[7:0];
        chk("ch1_frozen_val", (s1 == 8'd5) || (s1 == 8'd6), 1'b1);
        access("f1_rewrite", 1'b1, 8'hA0, 8'h06, 8'h00);
        wait_en(8);
        chk("freq_wr_keeps_phase", sample[7:0], s1);

`ifdef SCC_DEFORM_EN
        access("deform20", 1'b1, 8'hC0, 8'h20, 8'h00);
        access("f1_clr", 1'b1, 8'hA0, 8'h07, 8'h00);
        wait_en(8);
        chk("deform_phase_clr", sample[7:0], 8'h00);
        access("deform40", 1'b1, 8'hC0, 8'h40, 8'h00);
        access("locked_wr", 1'b1, 8'h23, 8'h00, 8'h00);
        access("locked_rd", 1'b0, 8'h23, 8'h00, 8'h5A);
        access("deform00", 1'b1, 8'hC0, 8'h00, 8'h00);
`endif

        // ---- ch2 frozen at period 5 over 1000 clk_en ----
        access("f2_lo", 1'b1, 8'hA2, 8'h05, 8'h00);
        access("f2_hi", 1'b1, 8'hA3, 8'h00, 8'h00);
        wait_en(8);
        s2 = sample[15:8];
        s1 = sample[7:0];
        changed = 1'b0;
        for (int it = 0; it < 1000; it++) begin
            wait_en(1);
            if (sample[15:8] != s2 || sample[7:0] != s1) changed = 1'b1;
        end
        chk("ch2_frozen", changed, 1'b0);

        // ---- req held across two CPU slots -> one ack; re-request ----
        @(negedge clk);
        req = 1'b1; wrt = 1'b0; adr = 8'h23;
        exp_q.push_back(8'h5A);
        wait_ack("hold1", 1'b0, lat);
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (ack) extra++;
        end
        chk("hold_no_reack", extra, 0);
        $display("hold req: first ack lat=%0d, extra acks=%0d", lat, extra);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        exp_q.push_back(8'h5A);
        wait_ack("hold2", 1'b0, lat);
        $display("re-request: ack lat=%0d", lat);
        @(negedge clk);
        req = 1'b0;

        // ---- reset while a write is pending in FETCH2 ----
        access("w00_99", 1'b1, 8'h00, 8'h99, 8'h00);
        access("w40_11", 1'b1, 8'h40, 8'h11, 8'h00);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        e0 = en_cnt;
        do begin
            @(posedge clk); #1;
        end while (en_cnt < e0 + 2);
        @(negedge clk);
        req = 1'b1; wrt = 1'b1; adr = 8'h40; dbo = 8'h77;
        seen = 1'b0;
        @(posedge clk); #1;
        if (ack) seen = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst2_sample", sample, 40'h0);
        chk("rst2_vol", vol, 20'h0);
        chk("rst2_ch_en", ch_en, 5'h0);
        chk("rst2_dbi", dbi, 8'h0);
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) seen = 1'b1;
        end
        chk("rst2_no_ack", seen, 1'b0);
        @(negedge clk);
        req = 1'b0;
        reset_n = 1'b1;
        e0 = en_cnt;
        do begin
            @(posedge clk); #1;
        end while (en_cnt < e0 + 1);
        chk("rst2_fetch0_lane1", sample[7:0], 8'h99);
        chk("rst2_fetch0_lane2", sample[15:8], 8'h00);
        $display("after reset: first fetch sample=%010h", sample);
        access("r40", 1'b0, 8'h40, 8'h00, 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
